// File: rtl/sum_accumulator.sv
// sum_accumulator: sums the 32-bit beats of a packet with valid/ready
// handshakes on both sides. It reports the total (mod 2^32), a sticky carry
// flag and a saturating beat count. One result is held until downstream
// takes it.
module sum_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_sum,
  output logic             o_carry,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no partial sum
    ACC  = 2'd1,  // partial sum held
    DONE = 2'd2   // result presented, waiting for downstream
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [32:0]      sum33;

  // The carry out of bit 31 is kept as bit 32 of a widened add.
  assign sum33 = {1'b0, acc_q} + {1'b0, i_data};

  // State and datapath registers; reset clears any partial or pending result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update. While a result is pending, the input side
  // is ignored. o_ready is low then, so no beat can be accepted anyway.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          acc_d   = i_data;
          carry_d = 1'b0;
          count_d = CNT_ONE;
          state_d = i_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (i_valid) begin
          acc_d   = sum33[31:0];
          carry_d = carry_q | sum33[32];
          // Count saturates; the sum keeps accumulating regardless.
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
          state_d = i_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, so there is no combinational
  // path from i_valid or i_ready.
  always_comb begin
    o_ready = (state_q != DONE);
    o_valid = (state_q == DONE);
  end

  assign o_sum   = acc_q;
  assign o_carry = carry_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator. Two instances (CNT_W=8 and CNT_W=2) share
// the same stimulus. A packet-level model tracks the exact unbounded total
// and the beat count. A per-cycle compare process checks both DUTs against
// the model. Directed scenarios also pin the model with literal values.
module tb_sum_accumulator;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_last;
  logic        i_ready;

  logic        o_ready_8, o_valid_8, o_carry_8;
  logic [31:0] o_sum_8;
  logic [7:0]  o_count_8;
  logic        o_ready_2, o_valid_2, o_carry_2;
  logic [31:0] o_sum_2;
  logic [1:0]  o_count_2;

  int tests_run = 0;
  int fails     = 0;

  sum_accumulator #(.CNT_W(8)) dut_w8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_8),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid_8), .i_ready(i_ready),
    .o_sum(o_sum_8), .o_carry(o_carry_8), .o_count(o_count_8)
  );

  sum_accumulator #(.CNT_W(2)) dut_w2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_2),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid_2), .i_ready(i_ready),
    .o_sum(o_sum_2), .o_carry(o_carry_2), .o_count(o_count_2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the exact packet total. The reported sum is its low
  // 32 bits. Carry is set once the true total has reached 2^32 (the total
  // only grows, so any carry shows up this way). The count is the number of
  // beats, clipped to the counter's maximum.
  logic        m_open;    // packet started, result not yet presented
  logic        m_done;    // result presented
  longint      m_total;
  int          m_beats;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_open  = 1'b0;
      m_done  = 1'b0;
      m_total = 0;
      m_beats = 0;
    end else if (m_done) begin
      if (i_ready) m_done = 1'b0;
    end else if (i_valid) begin
      if (!m_open) begin
        m_total = longint'(i_data);
        m_beats = 1;
      end else begin
        m_total = m_total + longint'(i_data);
        m_beats = m_beats + 1;
      end
      m_open = !i_last;
      m_done = i_last;
    end
  end

  function automatic logic [63:0] exp_count(input int width);
    int maxc;
    maxc = (1 << width) - 1;
    return (m_beats > maxc) ? 64'(maxc) : 64'(m_beats);
  endfunction

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;

  // Check both DUTs against the model on every falling edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("ready_w8", o_ready_8, !m_done);
      check("valid_w8", o_valid_8, m_done);
      check("ready_w2", o_ready_2, !m_done);
      check("valid_w2", o_valid_2, m_done);
      if (m_done || !i_rst_n) begin
        check("sum_w8",   o_sum_8,   64'(m_total[31:0]));
        check("carry_w8", o_carry_8, m_total >= 64'h1_0000_0000);
        check("count_w8", o_count_8, exp_count(8));
        check("sum_w2",   o_sum_2,   64'(m_total[31:0]));
        check("carry_w2", o_carry_2, m_total >= 64'h1_0000_0000);
        check("count_w2", o_count_2, exp_count(2));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic rand_ready = 1'b0;

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send_beat(input logic [31:0] d, input logic l);
    int   n;
    logic rdy;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    n = 0;
    do begin
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      rdy = o_ready_8;
      @(posedge i_clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("accept_timeout", 64'd0, 64'd1);
    i_valid = 1'b0;
    i_data  = $urandom;
    i_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] s,
                              input logic c, input logic [7:0] cnt);
    check({name, "_valid"}, o_valid_8, 1'b1);
    check({name, "_ready"}, o_ready_8, 1'b0);
    check({name, "_sum"},   o_sum_8,   s);
    check({name, "_carry"}, o_carry_8, c);
    check({name, "_count"}, o_count_8, cnt);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;

    #12;
    check("rst_ready", o_ready_8, 1'b1);
    check("rst_valid", o_valid_8, 1'b0);
    check("rst_sum",   o_sum_8,   32'd0);
    check("rst_carry", o_carry_8, 1'b0);
    check("rst_count", o_count_8, 8'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk_en = 1'b1;

    // 3-beat packet: the result appears in the cycle after the last beat.
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    check_result("three_beat", 32'd6, 1'b0, 8'd3);
    idle(1);

    // Wrap: the carry sets and the sum wraps.
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    check_result("wrap", 32'h1, 1'b1, 8'd2);
    idle(1);

    // Gaps between beats do not disturb the sum.
    send_beat(32'd10, 1'b0);
    idle(3);
    send_beat(32'd20, 1'b0);
    idle(2);
    send_beat(32'd30, 1'b1);
    check_result("gaps", 32'd60, 1'b0, 8'd3);
    idle(1);

    // One-beat packet.
    send_beat(32'hA5A5_A5A5, 1'b1);
    check_result("one_beat", 32'hA5A5_A5A5, 1'b0, 8'd1);
    idle(1);

    // Backpressure: the result is held and new input is ignored.
    i_ready = 1'b0;
    send_beat(32'd4, 1'b0);
    send_beat(32'd5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_data  = $urandom;
      i_last  = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      #1;
      check_result("bp_hold", 32'd9, 1'b0, 8'd2);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_release_valid", o_valid_8, 1'b0);
    check("bp_release_ready", o_ready_8, 1'b1);

    // Saturation: the 2-bit count stops at 3 and the sum keeps going.
    for (int k = 0; k < 5; k++) send_beat(32'd1, k == 4);
    check("sat_w2_count", o_count_2, 2'd3);
    check("sat_w2_sum",   o_sum_2,   32'd5);
    check("sat_w8_count", o_count_8, 8'd5);
    idle(1);

    // Reset mid-packet clears everything at once, without waiting for a clock edge.
    send_beat(32'd11, 1'b0);
    send_beat(32'd12, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rstmid_sum_w8",   o_sum_8,   32'd0);
    check("rstmid_count_w8", o_count_8, 8'd0);
    check("rstmid_sum_w2",   o_sum_2,   32'd0);
    check("rstmid_count_w2", o_count_2, 2'd0);
    check("rstmid_ready",    o_ready_8, 1'b1);
    check("rstmid_valid",    o_valid_8, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_beat(32'd7, 1'b1);
    check_result("after_rst", 32'd7, 1'b0, 8'd1);
    idle(1);

    // Random packets, random gaps and random downstream backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        logic [31:0] d;
        d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        send_beat(d, b == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the beat counter.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_valid, input, 1 bit: upstream has a beat on i_data.
REQ-005 The block SHALL have port o_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-006 The block SHALL have port i_data, input, 32 bits: operand beat.
REQ-007 The block SHALL have port i_last, input, 1 bit: the current beat is the final beat of a packet.
REQ-008 The block SHALL have port o_valid, output, 1 bit: a packet result is presented.
REQ-009 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port o_sum, output, 32 bits: packet total, modulo 2^32.
REQ-011 The block SHALL have port o_carry, output, 1 bit: sticky flag, set if any addition in the packet produced a carry out of bit 31.
REQ-012 The block SHALL have port o_count, output, CNT_W bits: number of beats accepted in the packet.

Function
REQ-013 Input handshake: a beat SHALL be accepted only in a cycle where i_valid=1 and o_ready=1 at the rising edge of i_clk.
REQ-014 Output handshake: a result SHALL be consumed only in a cycle where o_valid=1 and i_ready=1 at the rising edge of i_clk.
REQ-015 The FSM SHALL have exactly three states: IDLE (no partial sum), ACC (partial sum held) and DONE (result presented).
REQ-016 o_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-017 o_ready and o_valid SHALL be decoded from state only, with no combinational path from i_valid or i_ready.
REQ-018 o_valid SHALL be 1 in DONE only.
REQ-019 When a beat is accepted in IDLE:
- acc <= i_data, count <= 1, carry <= 0;
- the next state SHALL be DONE if i_last=1, else ACC.
REQ-020 When a beat is accepted in ACC:
- acc <= acc + i_data, computed with a 33-bit internal sum; bits [31:0] are kept;
- carry <= carry OR bit 32;
- count <= count + 1;
- the next state SHALL be DONE if i_last=1, else ACC.
REQ-021 In IDLE or ACC with no beat accepted, all registers SHALL hold.
REQ-022 count SHALL saturate at 2^CNT_W-1 and never wrap; accumulation SHALL continue while count is saturated.
REQ-023 acc SHALL wrap modulo 2^32; the wrap sets carry and has no other effect.
REQ-024 In DONE, o_sum, o_carry and o_count SHALL hold stable until the result is consumed.
REQ-025 In DONE, i_valid, i_data and i_last SHALL be ignored.
REQ-026 Latency: o_valid SHALL rise in the cycle after the i_last beat is accepted.
REQ-027 On consumption in DONE, the next state SHALL be IDLE, so the next packet's first beat is accepted no earlier than the following cycle (one-cycle bubble per packet).
REQ-028 o_sum, o_carry and o_count SHALL be driven directly from the acc, carry and count registers in all states; their values are defined to downstream only while o_valid=1.
REQ-029 i_last asserted on the first beat SHALL yield a one-beat packet: o_sum=i_data, o_count=1, o_carry=0.

Reset
REQ-030 While i_rst_n=0, the block SHALL immediately force, independent of i_clk:
- state=IDLE;
- acc=0, carry=0, count=0;
- therefore o_ready=1, o_valid=0, o_sum=0, o_carry=0, o_count=0.
REQ-031 Reset asserted in ACC or DONE SHALL discard the partial or pending result; no result is output for that packet.
REQ-032 After i_rst_n deasserts, the first rising edge with i_valid=1 SHALL be accepted as the first beat of a new packet.

Verification
REQ-033 The bench SHALL cover a 3-beat packet: beats 1, 2, 3 (last on 3), i_ready=1 -> o_valid one cycle after beat 3; o_sum=6, o_count=3, o_carry=0; o_ready=0 in that cycle.
REQ-034 The bench SHALL cover wrap: beats 0xFFFFFFFF and 0x00000002 (last) -> o_sum=0x00000001, o_carry=1, o_count=2.
REQ-035 The bench SHALL cover backpressure: result pending with i_ready=0 for 5 cycles while i_valid=1 with new data -> outputs constant, no beat accepted; i_ready=1 -> o_valid falls next cycle and o_ready=1.
REQ-036 The bench SHALL cover gaps and one-beat packets:
- i_valid low between beats -> sum unaffected;
- one-beat packet 0xA5A5A5A5 -> o_sum=0xA5A5A5A5, o_count=1.
REQ-037 The bench SHALL cover saturation with CNT_W=2: 5 beats of 1 -> o_count=3, o_sum=5.
REQ-038 The bench SHALL cover reset mid-packet: 2 beats accepted, then i_rst_n=0 between clock edges -> o_sum=0 and o_count=0 immediately; next packet 7 (last) -> o_sum=7, o_count=1.
